bin_to_bcd_seq: RTL and testbench

Parametrised, handshaked binary-to-BCD converter using iterative shift-add-3 (double dabble), one bit per clock. It feeds the 7-segment display digit mux with packed BCD digits and a per-digit leading-zero blank mask. It adds three things a fixed 14-bit/4-digit converter does not have: a start/done handshake, overflow saturation when the value does not fit in DIGITS, and leading-zero blanking.

---
 rtl/bin_to_bcd_seq.sv | 149 ++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock).
// Presents packed BCD digits, an overflow flag with 9...9 saturation, and a
// per-digit leading-zero blank mask for the 7-segment digit mux.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [BIN_W-1:0]      i_bin,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_ovf,
    output logic [DIGITS-1:0]     o_blank
);

    // Internal digit count: enough for 2^BIN_W-1, never fewer than DIGITS.
    localparam int NAT_DIG = (BIN_W + 2) / 3;
    localparam int INT_DIG = (NAT_DIG > DIGITS) ? NAT_DIG : DIGITS;
    localparam int BCD_W   = 4 * INT_DIG;
    localparam int SR_W    = BCD_W + BIN_W;
    localparam int CNT_W   = $clog2(BIN_W + 1);

    // Reset/idle blank mask: every digit off except the units digit.
    localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [SR_W-1:0]     sr_q, sr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic                ovf_q, ovf_d;
    logic [DIGITS-1:0]   blank_q, blank_d;
    logic                done_q, done_d;

    logic [BCD_W-1:0]    bcd_adj;
    logic [SR_W-1:0]     sr_shift;
    logic [BCD_W-1:0]    res_bcd;
    logic                hi_nz;
    logic [DIGITS:1]     lz;
    logic [DIGITS-1:0]   res_blank;
    logic [4*DIGITS-1:0] res_out;

    // Add-3 correction on every BCD digit that is 5 or more.
    for (genvar gi = 0; gi < INT_DIG; gi++) begin : g_adj
        logic [3:0] dig;
        assign dig = sr_q[BIN_W + 4*gi +: 4];
        assign bcd_adj[4*gi +: 4] = (dig >= 4'd5) ? dig + 4'd3 : dig;
    end

    // The top BCD bit is always zero after correction, so dropping it is safe.
    assign sr_shift = {bcd_adj, sr_q[BIN_W-1:0]} << 1;
    assign res_bcd  = sr_shift[SR_W-1 -: BCD_W];

    // Any nonzero digit above the displayed ones means the value does not fit.
    if (INT_DIG > DIGITS) begin : g_ovf
        assign hi_nz = |res_bcd[BCD_W-1:4*DIGITS];
    end else begin : g_no_ovf
        assign hi_nz = 1'b0;
    end

    // Leading-zero chain from the most significant displayed digit downward.
    assign lz[DIGITS] = 1'b1;
    for (genvar gi = 1; gi < DIGITS; gi++) begin : g_lz
        assign lz[gi] = lz[gi+1] & (res_bcd[4*gi +: 4] == 4'd0);
    end

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_blank
        if (gi == 0) begin : g_units
            assign res_blank[gi] = 1'b0;
        end else begin : g_upper
            assign res_blank[gi] = lz[gi] & ~hi_nz;
        end
    end

    assign res_out = hi_nz ? {DIGITS{4'h9}} : res_bcd[4*DIGITS-1:0];

    // Next-state logic: load on accept, shift while busy, publish on the last shift.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        blank_d = blank_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    sr_d    = {{BCD_W{1'b0}}, i_bin};
                    cnt_d   = CNT_W'(BIN_W);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sr_d  = sr_shift;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = res_out;
                    ovf_d   = hi_nz;
                    blank_d = res_blank;
                    done_d  = 1'b1;
                    state_d = IDLE;
                    // Accepting here keeps throughput at one result per BIN_W clocks.
                    if (i_start) begin
                        sr_d    = {{BCD_W{1'b0}}, i_bin};
                        cnt_d   = CNT_W'(BIN_W);
                        state_d = SHIFT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any conversion in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            blank_q <= BLANK_RST;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            blank_q <= blank_d;
            done_q  <= done_d;
        end
    end

    assign o_busy  = (state_q == SHIFT);
    assign o_done  = done_q;
    assign o_bcd   = bcd_q;
    assign o_ovf   = ovf_q;
    assign o_blank = blank_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: default 14-bit/4-digit build plus
// an 8-bit/2-digit build, directed vectors and handshake corner cases.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [13:0] bin;
    logic        busy, done, ovf;
    logic [15:0] bcd;
    logic [3:0]  blank;

    logic        start8;
    logic [7:0]  bin8;
    logic        busy8, done8, ovf8;
    logic [7:0]  bcd8;
    logic [1:0]  blank8;

    int total = 0;
    int bad   = 0;

    bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_bin(bin),
        .o_busy(busy), .o_done(done), .o_bcd(bcd), .o_ovf(ovf), .o_blank(blank)
    );

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_start(start8), .i_bin(bin8),
        .o_busy(busy8), .o_done(done8), .o_bcd(bcd8), .o_ovf(ovf8), .o_blank(blank8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Start a conversion, count edges after the accepting edge until o_done.
    task automatic run_conv(input logic [13:0] v, output logic [15:0] r_bcd,
                            output logic r_ovf, output logic [3:0] r_blank, output int lat);
        start = 1'b1;
        bin   = v;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        r_bcd = bcd; r_ovf = ovf; r_blank = blank;
    endtask

    task automatic run_conv8(input logic [7:0] v, output logic [7:0] r_bcd,
                             output logic r_ovf, output logic [1:0] r_blank, output int lat);
        start8 = 1'b1;
        bin8   = v;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        r_bcd = bcd8; r_ovf = ovf8; r_blank = blank8;
    endtask

    typedef struct {
        logic [13:0] bin;
        logic [15:0] bcd;
        logic        ovf;
        logic [3:0]  blank;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [15:0] r_bcd;
        logic        r_ovf;
        logic [3:0]  r_blank;
        logic [7:0]  r_bcd8;
        logic [1:0]  r_blank8;
        int          lat;
        int          n_done;
        int          done_edge[2];
        logic [15:0] done_bcd[2];

        vecs[0] = '{14'd0,     16'h0000, 1'b0, 4'b1110};
        vecs[1] = '{14'd1,     16'h0001, 1'b0, 4'b1110};
        vecs[2] = '{14'd34,    16'h0034, 1'b0, 4'b1100};
        vecs[3] = '{14'd529,   16'h0529, 1'b0, 4'b1000};
        vecs[4] = '{14'd1024,  16'h1024, 1'b0, 4'b0000};
        vecs[5] = '{14'd2222,  16'h2222, 1'b0, 4'b0000};
        vecs[6] = '{14'd9999,  16'h9999, 1'b0, 4'b0000};
        vecs[7] = '{14'd10000, 16'h9999, 1'b1, 4'b0000};
        vecs[8] = '{14'd16383, 16'h9999, 1'b1, 4'b0000};
        vecs[9] = '{14'd12,    16'h0012, 1'b0, 4'b1100};

        rst = 1'b1; start = 1'b0; bin = '0; start8 = 1'b0; bin8 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_bcd",   bcd,   16'h0000);
        check("rst_blank", blank, 4'b1110);
        check("rst_busy",  busy,  1'b0);
        check("rst_done",  done,  1'b0);
        check("rst_ovf",   ovf,   1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors.
        for (int i = 0; i < 10; i++) begin
            run_conv(vecs[i].bin, r_bcd, r_ovf, r_blank, lat);
            $display("vec %0d: bin=%0d bcd=%h ovf=%0b blank=%b lat=%0d",
                     i, vecs[i].bin, r_bcd, r_ovf, r_blank, lat);
            check("vec_bcd",   r_bcd,   vecs[i].bcd);
            check("vec_ovf",   r_ovf,   vecs[i].ovf);
            check("vec_blank", r_blank, vecs[i].blank);
            check("vec_lat",   lat,     14);
        end
        @(posedge clk); #1;

        // Handshake: busy/done timing, and a start pulse mid-conversion is ignored.
        start = 1'b1; bin = 14'd1024;
        @(posedge clk); #1;
        start = 1'b0;
        check("hs_busy_e0", busy, 1'b1);
        for (int e = 1; e <= 15; e++) begin
            if (e == 5) begin start = 1'b1; bin = 14'd7; end
            @(posedge clk); #1;
            start = 1'b0;
            check("hs_done", done, (e == 14) ? 1'b1 : 1'b0);
            check("hs_busy", busy, (e < 14) ? 1'b1 : 1'b0);
            if (e == 14) check("hs_bcd", bcd, 16'h1024);
        end
        $display("handshake: bcd=%h busy=%0b done=%0b", bcd, busy, done);

        // Back-to-back with start held high; the second value is sampled on the
        // edge that completes the first conversion.
        start = 1'b1; bin = 14'd34;
        @(posedge clk); #1;
        n_done = 0;
        for (int e = 1; e <= 32; e++) begin
            if (e == 14) bin = 14'd529;
            if (e == 28) start = 1'b0;
            @(posedge clk); #1;
            if (done) begin
                if (n_done < 2) begin
                    done_edge[n_done] = e;
                    done_bcd[n_done]  = bcd;
                end
                n_done++;
            end
        end
        $display("b2b: pulses=%0d", n_done);
        check("b2b_count", n_done, 2);
        if (n_done >= 2) begin
            check("b2b_edge0", done_edge[0], 14);
            check("b2b_edge1", done_edge[1], 28);
            check("b2b_bcd0",  done_bcd[0],  16'h0034);
            check("b2b_bcd1",  done_bcd[1],  16'h0529);
        end

        // Asynchronous reset between edges clears outputs before the next edge.
        run_conv(14'd2222, r_bcd, r_ovf, r_blank, lat);
        @(posedge clk); #1;
        rst = 1'b1;
        #2;
        $display("async rst: bcd=%h blank=%b", bcd, blank);
        check("arst_bcd",   bcd,   16'h0000);
        check("arst_blank", blank, 4'b1110);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Reset at edge 6 of a conversion aborts it with no o_done.
        start = 1'b1; bin = 14'd2222;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_bcd",   bcd,   16'h0000);
        check("mid_blank", blank, 4'b1110);
        check("mid_busy",  busy,  1'b0);
        check("mid_ovf",   ovf,   1'b0);
        n_done = 0;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        check("mid_nodone", n_done, 0);
        run_conv(14'd2222, r_bcd, r_ovf, r_blank, lat);
        $display("after abort: bcd=%h lat=%0d", r_bcd, lat);
        check("mid_next_bcd", r_bcd, 16'h2222);
        check("mid_next_lat", lat,   14);

        // 8-bit / 2-digit build.
        run_conv8(8'd255, r_bcd8, r_ovf, r_blank8, lat);
        $display("w8: bin=255 bcd=%h ovf=%0b blank=%b lat=%0d", r_bcd8, r_ovf, r_blank8, lat);
        check("w8_255_bcd",   r_bcd8,   8'h99);
        check("w8_255_ovf",   r_ovf,    1'b1);
        check("w8_255_blank", r_blank8, 2'b00);
        run_conv8(8'd99, r_bcd8, r_ovf, r_blank8, lat);
        $display("w8: bin=99 bcd=%h ovf=%0b blank=%b lat=%0d", r_bcd8, r_ovf, r_blank8, lat);
        check("w8_99_bcd", r_bcd8, 8'h99);
        check("w8_99_ovf", r_ovf,  1'b0);
        check("w8_99_lat", lat,    8);
        run_conv8(8'd5, r_bcd8, r_ovf, r_blank8, lat);
        $display("w8: bin=5 bcd=%h ovf=%0b blank=%b lat=%0d", r_bcd8, r_ovf, r_blank8, lat);
        check("w8_5_bcd",   r_bcd8,   8'h05);
        check("w8_5_blank", r_blank8, 2'b10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
